// File: rtl/ram_param_clr.sv
// Parametrised single-port word RAM with a hardware clear sweep and busy flag.
// Optional registered read port selected by defining RAM_OUT_REG_EN.
module ram_param_clr #(
    parameter int              WIDTH   = 16,
    parameter int              ADDR_W  = 9,
    parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_STEP  = ADDR_W'(1'b1);
    localparam logic [WIDTH-1:0]  ZERO_WORD = {WIDTH{1'b0}};

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Sweep controller: reset lands in CLEAR so memory is always initialised after power-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            ptr   <= PTR_ZERO;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (ptr == LAST_ADDR) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        ptr <= ptr + PTR_STEP;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= PTR_ZERO;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= PTR_ZERO;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage: the sweep owns the write port while clearing, so user writes are dropped
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= CLR_VAL;
        end else if (load) begin
            mem[address] <= in;
        end
    end

`ifdef RAM_OUT_REG_EN
    // Registered read, read-before-write; forced to zero for every edge spent in CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= ZERO_WORD;
        end else if (state == CLEAR) begin
            out <= ZERO_WORD;
        end else begin
            out <= mem[address];
        end
    end
`else
    // Combinational read, masked while the sweep is running
    always_comb begin
        out = ZERO_WORD;
        if (busy) begin
            out = ZERO_WORD;
        end else begin
            out = mem[address];
        end
    end
`endif

endmodule

// File: tb/tb_ram_param_clr.sv
// Randomised self-checking bench for ram_param_clr against an array reference model.
// Expectations for read latency follow RAM_OUT_REG_EN when the bench is built with it.
module tb_ram_param_clr;

    logic        clk;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic [8:0]  address;
    logic        clear;
    logic [15:0] out;
    logic        busy;

    logic [7:0]  s_in;
    logic        s_load;
    logic [3:0]  s_address;
    logic        s_clear;
    logic [7:0]  s_out;
    logic        s_busy;

    int n_tests;
    int n_fail;
    int s_len;
    int len;

    logic [15:0] ref_mem [512];

`ifdef RAM_OUT_REG_EN
    localparam bit REG_OUT = 1'b1;
`else
    localparam bit REG_OUT = 1'b0;
`endif

    ram_param_clr u_dut (
        .clk(clk), .rst_n(rst_n), .in(in), .load(load), .address(address),
        .clear(clear), .out(out), .busy(busy)
    );

    ram_param_clr #(.WIDTH(8), .ADDR_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .in(s_in), .load(s_load), .address(s_address),
        .clear(s_clear), .out(s_out), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 512; i++) ref_mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load  = 1'b0;
        clear = 1'b0;
        #1;
        check_eq("reset_busy", {31'd0, busy}, 32'd1);
        check_eq("reset_out", {16'd0, out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // kind 1: persistent write of beef@500 from edge inj_at; kind 2: one-cycle clear pulse
    task automatic run_sweep(input int inj_at, input int kind, input bit chk_out, output int n);
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (!s_busy && s_len < 0) s_len = n;
            if (busy) begin
                if (chk_out) check_eq("busy_out_zero", {16'd0, out}, 32'd0);
                if (n == inj_at && kind == 1) begin
                    load = 1'b1; address = 9'd500; in = 16'hbeef;
                end else if (n == inj_at && kind == 2) begin
                    clear = 1'b1;
                end else if (n == inj_at + 1 && kind == 2) begin
                    clear = 1'b0;
                end
            end else begin
                done = 1'b1;
            end
        end
        load  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic write_word(input logic [8:0] a, input logic [15:0] d);
        logic [15:0] old;
        @(negedge clk);
        address = a; in = d; load = 1'b1;
        old = ref_mem[a];
        @(posedge clk);
        #1;
        ref_mem[a] = d;
        check_eq("write_same_edge", {16'd0, out}, {16'd0, (REG_OUT ? old : d)});
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic read_word(input logic [8:0] a);
        @(negedge clk);
        load = 1'b0; address = a;
        @(posedge clk);
        #1;
        check_eq("read", {16'd0, out}, {16'd0, ref_mem[a]});
    endtask

    initial begin
        n_tests = 0; n_fail = 0; s_len = -1;
        rst_n = 1'b0; load = 1'b0; clear = 1'b0; address = 9'd0; in = 16'd0;
        s_in = 8'd0; s_load = 1'b0; s_address = 4'd0; s_clear = 1'b0;

        // 1: reset sweep length on both instances
        do_reset();
        run_sweep(0, 0, 1'b1, len);
        check_eq("reset_sweep_len", len, 32'd512);
        check_eq("small_sweep_len", s_len, 32'd16);
        model_clear();
        read_word(9'd0); read_word(9'd255); read_word(9'd511);

        // 2: directed writes plus an untouched neighbour
        write_word(9'd1, 16'h0001); write_word(9'd8, 16'h2008);
        write_word(9'd10, 16'h300a); write_word(9'd263, 16'h7263);
        write_word(9'd511, 16'h7511);
        read_word(9'd1); read_word(9'd8); read_word(9'd10);
        read_word(9'd263); read_word(9'd511); read_word(9'd2);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(1, 0) == 1)
                write_word(9'($urandom_range(511, 0)), 16'($urandom));
            else
                read_word(9'($urandom_range(511, 0)));
        end

        // 3: writes during a reset sweep are ignored
        do_reset();
        run_sweep(100, 1, 1'b1, len);
        check_eq("sweep_len_load", len, 32'd512);
        model_clear();
        read_word(9'd500);

        // 4: clear request with a same-edge write
        for (int i = 0; i < 10; i++) write_word(9'($urandom_range(511, 0)), 16'($urandom));
        @(negedge clk);
        load = 1'b1; clear = 1'b1; address = 9'd7; in = 16'h1234;
        @(posedge clk);
        #1;
        load = 1'b0; clear = 1'b0;
        check_eq("clear_busy_rise", {31'd0, busy}, 32'd1);
        run_sweep(0, 0, 1'b0, len);
        check_eq("clear_sweep_len", len, 32'd512);
        model_clear();
        read_word(9'd7);
        for (int i = 0; i < 6; i++) read_word(9'($urandom_range(511, 0)));

        // 5: reset mid-sweep restarts; a clear pulse during the sweep does not extend it
        write_word(9'd300, 16'h5a5a);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        repeat (300) @(posedge clk);
        do_reset();
        run_sweep(200, 2, 1'b1, len);
        check_eq("restart_sweep_len", len, 32'd512);
        model_clear();
        read_word(9'd300); read_word(9'd0);

        // 6: read latency of 5037@37 and the narrow instance
        write_word(9'd37, 16'h5037);
        read_word(9'd0);
        @(negedge clk);
        address = 9'd37;
        #1;
        check_eq("latency_pre_edge", {16'd0, out}, {16'd0, (REG_OUT ? ref_mem[0] : ref_mem[37])});
        @(posedge clk);
        #1;
        check_eq("latency_post_edge", {16'd0, out}, 32'h5037);

        @(negedge clk);
        s_address = 4'd15; s_in = 8'ha5; s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        @(posedge clk);
        #1;
        check_eq("small_rd15", {24'd0, s_out}, 32'ha5);
        @(negedge clk);
        s_address = 4'd14;
        @(posedge clk);
        #1;
        check_eq("small_rd14", {24'd0, s_out}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
